// File: rtl/atan2_ctrl_pkg.sv
// atan2_ctrl_pkg
//   Shared definitions for the atan2 job controller: register word offsets,
//   CTRL/STATUS bit positions and the job FSM state encoding.
package atan2_ctrl_pkg;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_DONE    = 1;
  localparam int unsigned STATUS_TIMEOUT = 2;
  localparam int unsigned STATUS_OVERRUN = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/atan2_job_ctrl.sv
// atan2_job_ctrl
//   Avalon-MM slave that runs one atan2 job at a time on an external CORDIC
//   core: CPU writes operands A/B and GO, the block launches the core with a
//   start/ready handshake, waits for result_valid (bounded by a timeout),
//   latches RESULT and sets DONE (optionally raising irq).
// Ports
//   clk, reset_n                     clock, async active-low reset
//   address/chipselect/write_n/
//   writedata/readdata               Avalon-MM slave, word offsets 0..4
//   irq                              level interrupt, DONE & IRQ_EN
//   core_start/core_ready            launch handshake to the core
//   core_a/core_b                    operands held for the in-flight job
//   core_valid/core_result           one-cycle result strobe and data
import atan2_ctrl_pkg::*;

module atan2_job_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              core_start,
  input  logic              core_ready,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_result
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_e            state, state_d;
  logic [DATA_W-1:0] a_reg, b_reg, result_reg;
  logic              irq_en, done, timeout_flag, overrun;
  logic [CNT_W-1:0]  cnt;

  logic wr, wr_ctrl, go, clr, launch, timed_out;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == ADDR_CTRL);
  assign go      = wr_ctrl & writedata[CTRL_GO];
  assign clr     = wr_ctrl & writedata[CTRL_CLR];
  assign launch  = go && (state == IDLE);

  // cnt holds the number of WAIT cycles already spent; the abort fires on the
  // edge that would complete the TIMEOUT_CYCLES-th one.
  assign timed_out = TIMEOUT_EN && (state == WAIT) && !core_valid && (cnt == CNT_LAST);

  assign irq = done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d    = state;
    core_start = 1'b0;
    case (state)
      IDLE:   if (go) state_d = LAUNCH;
      LAUNCH: begin
        core_start = 1'b1;
        if (core_ready) state_d = WAIT;
      end
      WAIT:   if (core_valid || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      core_a       <= '0;
      core_b       <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      timeout_flag <= 1'b0;
      overrun      <= 1'b0;
      cnt          <= '0;
    end else begin
      if (wr && address == ADDR_A) a_reg <= DATA_W'(writedata);
      if (wr && address == ADDR_B) b_reg <= DATA_W'(writedata);
      if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];

      // Later assignments win: CLR is applied before launch/overrun/completion.
      if (clr) begin
        done         <= 1'b0;
        timeout_flag <= 1'b0;
        overrun      <= 1'b0;
      end

      if (launch) begin
        core_a <= a_reg;
        core_b <= b_reg;
        done   <= 1'b0;
      end else if (go) begin
        overrun <= 1'b1;
      end

      if (state == WAIT && core_valid) begin
        result_reg <= core_result;
        done       <= 1'b1;
      end else if (timed_out) begin
        timeout_flag <= 1'b1;
        done         <= 1'b1;
      end

      if (state == LAUNCH)                 cnt <= '0;
      else if (state == WAIT && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_A:      readdata = 32'(a_reg);
      ADDR_B:      readdata = 32'(b_reg);
      ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY]    = (state != IDLE);
        readdata[STATUS_DONE]    = done;
        readdata[STATUS_TIMEOUT] = timeout_flag;
        readdata[STATUS_OVERRUN] = overrun;
      end
      ADDR_RESULT: readdata = 32'(result_reg);
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_atan2_job_ctrl.sv
// tb_atan2_job_ctrl
//   Directed bench for atan2_job_ctrl. Two instances share the bus and core
//   inputs: u_dut with the default timeout, u_dut_to with TIMEOUT_CYCLES=16.
//   Stimulus is applied on the falling edge; outputs are sampled there too.
module tb_atan2_job_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        core_ready;
  logic        core_valid;
  logic [31:0] core_result;

  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1, start0, start1;
  logic [31:0] a0, b0, a1, b1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  atan2_job_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata0), .irq(irq0),
    .core_start(start0), .core_ready(core_ready), .core_a(a0), .core_b(b0),
    .core_valid(core_valid), .core_result(core_result)
  );

  atan2_job_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(16)) u_dut_to (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata1), .irq(irq1),
    .core_start(start1), .core_ready(core_ready), .core_a(a1), .core_b(b1),
    .core_valid(core_valid), .core_result(core_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a falling edge; the write is taken on the next rising edge.
  task automatic bus_wr(input logic [2:0] adr, input logic [31:0] data);
    address    = adr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Combinational read; does not advance the clock.
  task automatic bus_rd(input logic [2:0] adr, output logic [31:0] d0, output logic [31:0] d1);
    address    = adr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d0 = rdata0;
    d1 = rdata1;
    chipselect = 1'b0;
  endtask

  task automatic pulse_valid(input logic [31:0] res);
    core_valid  = 1'b1;
    core_result = res;
    @(negedge clk);
    core_valid  = 1'b0;
    core_result = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d0, d1;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; core_ready = 1'b0; core_valid = 1'b0; core_result = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_start", {31'b0, start0}, 32'h0);
    check("rst_irq",   {31'b0, irq0}, 32'h0);
    check("rst_core_a", a0, 32'h0);
    bus_rd(3'd3, d0, d1); check("rst_status", d0, 32'h0);
    bus_rd(3'd4, d0, d1); check("rst_result", d0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic job, core ready immediately
    core_ready = 1'b1;
    bus_wr(3'd0, 32'h0000_0100);
    bus_wr(3'd1, 32'h0000_0100);
    bus_wr(3'd2, 32'h1);
    check("t1_start_hi", {31'b0, start0}, 32'h1);
    check("t1_core_a", a0, 32'h100);
    check("t1_core_b", b0, 32'h100);
    @(negedge clk);
    check("t1_start_lo", {31'b0, start0}, 32'h0);
    bus_rd(3'd3, d0, d1); check("t1_busy", d0, 32'h1);
    repeat (18) @(negedge clk);
    pulse_valid(32'h0000_3244);
    bus_rd(3'd3, d0, d1); check("t1_status", d0, 32'h2);
    bus_rd(3'd4, d0, d1); check("t1_result", d0, 32'h3244);
    check("t1_irq_off", {31'b0, irq0}, 32'h0);
    bus_rd(3'd5, d0, d1); check("t1_unmapped", d0, 32'h0);

    // 2: core holds off launch for 10 cycles
    core_ready = 1'b0;
    bus_wr(3'd2, 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("t2_start", {31'b0, start0}, 32'h1);
      check("t2_core_a", a0, 32'h100);
      bus_rd(3'd3, d0, d1); check("t2_status", d0, 32'h1);
      @(negedge clk);
    end
    core_ready = 1'b1;
    @(negedge clk);
    check("t2_start_lo", {31'b0, start0}, 32'h0);
    pulse_valid(32'h0000_1111);
    bus_rd(3'd3, d0, d1); check("t2_status_done", d0, 32'h2);
    bus_rd(3'd4, d0, d1); check("t2_result", d0, 32'h1111);

    // 3: interrupt enable and clear
    bus_wr(3'd2, 32'h2);
    bus_rd(3'd2, d0, d1); check("t3_ctrl_rd", d0, 32'h2);
    bus_wr(3'd2, 32'h3);
    repeat (3) @(negedge clk);
    check("t3_irq_wait", {31'b0, irq0}, 32'h0);
    core_valid = 1'b1; core_result = 32'h2222;
    #1 check("t3_irq_pre", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    core_valid = 1'b0; core_result = '0;
    check("t3_irq_hi", {31'b0, irq0}, 32'h1);
    bus_rd(3'd3, d0, d1); check("t3_status", d0, 32'h2);
    bus_wr(3'd2, 32'h6);
    check("t3_irq_clr", {31'b0, irq0}, 32'h0);
    bus_rd(3'd3, d0, d1); check("t3_status_clr", d0, 32'h0);
    bus_rd(3'd2, d0, d1); check("t3_ctrl_keep", d0, 32'h2);

    // 4: timeout on the 16-cycle instance
    do_reset();
    core_ready = 1'b1;
    bus_wr(3'd2, 32'h1);
    repeat (16) @(negedge clk);
    bus_rd(3'd3, d0, d1); check("t4_still_busy", d1, 32'h1);
    @(negedge clk);
    bus_rd(3'd3, d0, d1); check("t4_timeout", d1, 32'h6);
    check("t4_start", {31'b0, start1}, 32'h0);
    pulse_valid(32'h0000_BEEF);
    bus_rd(3'd4, d0, d1); check("t4_result_kept", d1, 32'h0);
    bus_rd(3'd3, d0, d1); check("t4_status_kept", d1, 32'h6);

    // 5: GO and A write while busy
    do_reset();
    core_ready = 1'b0;
    bus_wr(3'd0, 32'h11);
    bus_wr(3'd1, 32'h22);
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd0, 32'hDEAD);
    bus_wr(3'd2, 32'h1);
    bus_rd(3'd0, d0, d1); check("t5_a_reg", d0, 32'hDEAD);
    check("t5_core_a", a0, 32'h11);
    check("t5_core_b", b0, 32'h22);
    bus_rd(3'd3, d0, d1); check("t5_status_busy", d0, 32'h9);
    core_ready = 1'b1;
    @(negedge clk);
    pulse_valid(32'h5555);
    bus_rd(3'd3, d0, d1); check("t5_status_done", d0, 32'hA);
    bus_wr(3'd2, 32'h1);
    check("t5_core_a_new", a0, 32'hDEAD);
    bus_rd(3'd3, d0, d1); check("t5_status_relaunch", d0, 32'h9);
    @(negedge clk);
    pulse_valid(32'h6666);
    bus_wr(3'd2, 32'h4);
    bus_rd(3'd3, d0, d1); check("t5_status_clr", d0, 32'h0);
    bus_rd(3'd4, d0, d1); check("t5_result", d0, 32'h6666);

    // 6: reset during WAIT, then a clean job
    bus_wr(3'd0, 32'h5);
    bus_wr(3'd1, 32'h7);
    bus_wr(3'd2, 32'h3);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_start", {31'b0, start0}, 32'h0);
    check("t6_irq", {31'b0, irq0}, 32'h0);
    check("t6_core_a", a0, 32'h0);
    check("t6_core_b", b0, 32'h0);
    for (int r = 0; r < 5; r++) begin
      bus_rd(3'(r), d0, d1); check("t6_reg", d0, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_wr(3'd0, 32'h5);
    bus_wr(3'd1, 32'h7);
    bus_wr(3'd2, 32'h1);
    check("t6_start_new", {31'b0, start0}, 32'h1);
    repeat (5) @(negedge clk);
    pulse_valid(32'h1234);
    bus_rd(3'd3, d0, d1); check("t6_status", d0, 32'h2);
    bus_rd(3'd4, d0, d1); check("t6_result", d0, 32'h1234);
    check("t6_core_a_new", a0, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
